// File: rtl/aibcr3_bufseq_pkg.sv
// aibcr3_bufseq_pkg: shared types and helpers for the AIB buffer power-up sequencer.
package aibcr3_bufseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PADRST,
        ST_RXON,
        ST_TXRAMP,
        ST_ACTIVE,
        ST_RAMPDN
    } state_e;

    typedef logic [1:0] drv_t;

    // One ramp-up step toward the target, holding once the target is reached.
    function automatic drv_t drv_inc(input drv_t cur, input drv_t tgt);
        return (cur < tgt) ? drv_t'(cur + 2'd1) : cur;
    endfunction

    // One ramp-down step, holding at zero.
    function automatic drv_t drv_dec(input drv_t cur);
        return (cur != 2'd0) ? drv_t'(cur - 2'd1) : cur;
    endfunction

endpackage

// File: rtl/aibcr3_bufseq_tmr.sv
// aibcr3_bufseq_tmr: down-counting dwell timer; done is high while the count is zero.
module aibcr3_bufseq_tmr #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         count_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    // Load has priority; otherwise count down and stop at zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/aibcr3_bufseq_ctl.sv
// aibcr3_bufseq_ctl: power-up / power-down sequencer for an AIB I/O buffer.
// Optional weak pull-down during IDLE/PADRST is built with AIBCR3_BUFSEQ_WEAKPULL_EN.
module aibcr3_bufseq_ctl
    import aibcr3_bufseq_pkg::*;
#(
    parameter int unsigned PADRST_CYC = 8,
    parameter int unsigned SETTLE_CYC = 4,
    parameter logic [2:0]  RXEN_ON    = 3'b001,
    parameter logic [2:0]  RXEN_OFF   = 3'b000
) (
    input  logic       iclk,
    input  logic       irstb,
    input  logic       por_aib_vcc1,
    input  logic       por_aib_vcchssi,
    input  logic       en_req,
    input  logic [1:0] cfg_pdrv,
    input  logic [1:0] cfg_ndrv,
    output logic       en_ack,
    output logic       busy,
    output logic       ipadrstb,
    output logic [2:0] irxen,
    output logic       itxen,
    output logic [1:0] ipdrv,
    output logic [1:0] indrv,
    output logic       test_weakpu,
    output logic       test_weakpd
);

`ifdef AIBCR3_BUFSEQ_WEAKPULL_EN
    localparam logic WEAKPD_IDLE = 1'b1;
`else
    localparam logic WEAKPD_IDLE = 1'b0;
`endif

    localparam int unsigned MAXC = (PADRST_CYC > SETTLE_CYC) ? PADRST_CYC : SETTLE_CYC;
    localparam int unsigned TW   = $clog2(MAXC + 1);
    localparam logic [TW-1:0] PAD_LD = TW'(PADRST_CYC - 1);
    localparam logic [TW-1:0] SET_LD = TW'(SETTLE_CYC - 1);

    logic          sync1_q, por_ok_q;
    state_e        state_q;
    drv_t          tgt_p_q, tgt_n_q, ipdrv_q, indrv_q;
    logic          ipadrstb_q, itxen_q, en_ack_q, busy_q, weakpd_q;
    logic [2:0]    irxen_q;
    logic          tmr_load, tmr_count, tmr_done;
    logic [TW-1:0] tmr_val;

    // Two-flop synchronizer for the combined power-good indication.
    always_ff @(posedge iclk or negedge irstb) begin
        if (!irstb) begin
            sync1_q  <= 1'b0;
            por_ok_q <= 1'b0;
        end else begin
            sync1_q  <= ~(por_aib_vcc1 | por_aib_vcchssi);
            por_ok_q <= sync1_q;
        end
    end

    // Timer reload on every state entry and every ramp step; the load is timed
    // to coincide with the FSM edge so each dwell is exactly N cycles.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_val   = SET_LD;
        tmr_count = (state_q != ST_IDLE) && (state_q != ST_ACTIVE);
        if (!por_ok_q) begin
            tmr_load = 1'b1;
            tmr_val  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tmr_load = en_req;
                    tmr_val  = PAD_LD;
                end
                ST_PADRST, ST_RXON, ST_TXRAMP: tmr_load = tmr_done | ~en_req;
                ST_ACTIVE:                     tmr_load = ~en_req;
                ST_RAMPDN:                     tmr_load = tmr_done;
                default:                       tmr_load = 1'b0;
            endcase
        end
    end

    aibcr3_bufseq_tmr #(.W(TW)) u_tmr (
        .clk_i   (iclk),
        .rst_n_i (irstb),
        .load_i  (tmr_load),
        .val_i   (tmr_val),
        .count_i (tmr_count),
        .done_o  (tmr_done)
    );

    // Sequencer FSM; all buffer controls are registered on the transition edge.
    always_ff @(posedge iclk or negedge irstb) begin
        if (!irstb) begin
            state_q    <= ST_IDLE;
            ipadrstb_q <= 1'b0;
            irxen_q    <= RXEN_OFF;
            itxen_q    <= 1'b0;
            ipdrv_q    <= '0;
            indrv_q    <= '0;
            tgt_p_q    <= '0;
            tgt_n_q    <= '0;
            en_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
            weakpd_q   <= WEAKPD_IDLE;
        end else if (!por_ok_q) begin
            state_q    <= ST_IDLE;
            ipadrstb_q <= 1'b0;
            irxen_q    <= RXEN_OFF;
            itxen_q    <= 1'b0;
            ipdrv_q    <= '0;
            indrv_q    <= '0;
            en_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
            weakpd_q   <= WEAKPD_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_req) begin
                        state_q <= ST_PADRST;
                        tgt_p_q <= cfg_pdrv;
                        tgt_n_q <= cfg_ndrv;
                        busy_q  <= 1'b1;
                    end
                end
                ST_PADRST, ST_RXON, ST_TXRAMP: begin
                    if (!en_req) begin
                        state_q  <= ST_RAMPDN;
                        weakpd_q <= 1'b0;
                    end else if (tmr_done) begin
                        if (state_q == ST_PADRST) begin
                            state_q    <= ST_RXON;
                            ipadrstb_q <= 1'b1;
                            irxen_q    <= RXEN_ON;
                            weakpd_q   <= 1'b0;
                        end else if (state_q == ST_RXON) begin
                            state_q <= ST_TXRAMP;
                            itxen_q <= 1'b1;
                            ipdrv_q <= '0;
                            indrv_q <= '0;
                        end else if ((ipdrv_q == tgt_p_q) && (indrv_q == tgt_n_q)) begin
                            state_q  <= ST_ACTIVE;
                            busy_q   <= 1'b0;
                            en_ack_q <= 1'b1;
                        end else begin
                            ipdrv_q <= drv_inc(ipdrv_q, tgt_p_q);
                            indrv_q <= drv_inc(indrv_q, tgt_n_q);
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!en_req) begin
                        state_q  <= ST_RAMPDN;
                        busy_q   <= 1'b1;
                        en_ack_q <= 1'b0;
                    end
                end
                ST_RAMPDN: begin
                    if (tmr_done) begin
                        if ((ipdrv_q == '0) && (indrv_q == '0)) begin
                            state_q    <= ST_IDLE;
                            itxen_q    <= 1'b0;
                            irxen_q    <= RXEN_OFF;
                            ipadrstb_q <= 1'b0;
                            busy_q     <= 1'b0;
                            weakpd_q   <= WEAKPD_IDLE;
                        end else begin
                            ipdrv_q <= drv_dec(ipdrv_q);
                            indrv_q <= drv_dec(indrv_q);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign en_ack      = en_ack_q;
    assign busy        = busy_q;
    assign ipadrstb    = ipadrstb_q;
    assign irxen       = irxen_q;
    assign itxen       = itxen_q;
    assign ipdrv       = ipdrv_q;
    assign indrv       = indrv_q;
    assign test_weakpu = 1'b0;
    assign test_weakpd = weakpd_q;

endmodule

// File: tb/tb_aibcr3_bufseq_ctl.sv
// tb_aibcr3_bufseq_ctl: directed checks of the buffer sequencer with default parameters.
// Honors AIBCR3_BUFSEQ_WEAKPULL_EN when computing weak-pull expectations.
module tb_aibcr3_bufseq_ctl;

`ifdef AIBCR3_BUFSEQ_WEAKPULL_EN
    localparam logic WP = 1'b1;
`else
    localparam logic WP = 1'b0;
`endif

    logic       iclk = 1'b0;
    logic       irstb, por_aib_vcc1, por_aib_vcchssi, en_req;
    logic [1:0] cfg_pdrv, cfg_ndrv;
    logic       en_ack, busy, ipadrstb, itxen, test_weakpu, test_weakpd;
    logic [2:0] irxen;
    logic [1:0] ipdrv, indrv;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 iclk = ~iclk;

    aibcr3_bufseq_ctl dut (
        .iclk            (iclk),
        .irstb           (irstb),
        .por_aib_vcc1    (por_aib_vcc1),
        .por_aib_vcchssi (por_aib_vcchssi),
        .en_req          (en_req),
        .cfg_pdrv        (cfg_pdrv),
        .cfg_ndrv        (cfg_ndrv),
        .en_ack          (en_ack),
        .busy            (busy),
        .ipadrstb        (ipadrstb),
        .irxen           (irxen),
        .itxen           (itxen),
        .ipdrv           (ipdrv),
        .indrv           (indrv),
        .test_weakpu     (test_weakpu),
        .test_weakpd     (test_weakpd)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_drv(input string tag, input logic [1:0] p, input logic [1:0] n);
        check(tag, {4'h0, ipdrv, indrv}, {4'h0, p, n});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge iclk);
        #1;
    endtask

    // Poll busy (sel=0) or en_ack (sel=1) after each edge, bounded by maxc cycles.
    task automatic wait_hi(input string tag, input int sel, input int maxc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            cyc(1);
            seen = (sel != 0) ? en_ack : busy;
        end
        check(tag, {7'h0, seen}, 8'h01);
    endtask

    initial begin
        irstb = 1'b0; por_aib_vcc1 = 1'b0; por_aib_vcchssi = 1'b0;
        en_req = 1'b0; cfg_pdrv = 2'd0; cfg_ndrv = 2'd0;
        #3;
        check("rst_padrstb", {7'h0, ipadrstb}, 8'h00);
        check("rst_irxen",   {5'h0, irxen},    8'h00);
        check("rst_itxen",   {7'h0, itxen},    8'h00);
        check_drv("rst_drv", 2'd0, 2'd0);
        check("rst_ack",     {7'h0, en_ack},   8'h00);
        check("rst_busy",    {7'h0, busy},     8'h00);
        check("rst_weakpu",  {7'h0, test_weakpu}, 8'h00);
        check("rst_weakpd",  {7'h0, test_weakpd}, {7'h0, WP});
        repeat (2) @(posedge iclk);
        #1 irstb = 1'b1;
        cyc(4);
        check("idle_busy",   {7'h0, busy},        8'h00);
        check("idle_weakpd", {7'h0, test_weakpd}, {7'h0, WP});

        // Full bring-up to 3/2; cfg changes after capture are ignored.
        cfg_pdrv = 2'd3; cfg_ndrv = 2'd2; en_req = 1'b1;
        wait_hi("start1", 0, 6);
        cfg_pdrv = 2'd0; cfg_ndrv = 2'd0;
        check("padrst_low0", {7'h0, ipadrstb}, 8'h00);
        for (int i = 1; i < 8; i++) begin
            cyc(1);
            check("padrst_low", {7'h0, ipadrstb}, 8'h00);
        end
        cyc(1);
        check("padrst_rel",  {7'h0, ipadrstb}, 8'h01);
        check("rxen_on",     {5'h0, irxen},    8'h01);
        check("txen_early0", {7'h0, itxen},    8'h00);
        cyc(3);
        check("txen_early3", {7'h0, itxen},    8'h00);
        cyc(1);
        check("txen_on",     {7'h0, itxen},    8'h01);
        check_drv("ramp0", 2'd0, 2'd0);
        cyc(4); check_drv("ramp1", 2'd1, 2'd1);
        cyc(4); check_drv("ramp2", 2'd2, 2'd2);
        cyc(4); check_drv("ramp3", 2'd3, 2'd2);
        check("ack_early", {7'h0, en_ack}, 8'h00);
        cyc(3);
        check("ack_early3", {7'h0, en_ack}, 8'h00);
        cyc(1);
        check("ack_on",      {7'h0, en_ack},      8'h01);
        check("active_busy", {7'h0, busy},        8'h00);
        check("act_weakpd",  {7'h0, test_weakpd}, 8'h00);
        check("act_weakpu",  {7'h0, test_weakpu}, 8'h00);

        // Ramp-down from ACTIVE; en_req re-asserted mid ramp-down has no effect.
        en_req = 1'b0;
        cyc(1);
        check("dn_busy", {7'h0, busy},   8'h01);
        check("dn_ack",  {7'h0, en_ack}, 8'h00);
        check_drv("dn0", 2'd3, 2'd2);
        cyc(4); check_drv("dn1", 2'd2, 2'd1);
        en_req = 1'b1;
        cyc(4); check_drv("dn2", 2'd1, 2'd0);
        cyc(4); check_drv("dn3", 2'd0, 2'd0);
        check("dn3_txen", {7'h0, itxen}, 8'h01);
        en_req = 1'b0;
        cyc(4);
        check("dn_idle_txen", {7'h0, itxen},    8'h00);
        check("dn_idle_rxen", {5'h0, irxen},    8'h00);
        check("dn_idle_prst", {7'h0, ipadrstb}, 8'h00);
        check("dn_idle_busy", {7'h0, busy},     8'h00);
        check("dn_idle_ack",  {7'h0, en_ack},   8'h00);
        check("dn_idle_wpd",  {7'h0, test_weakpd}, {7'h0, WP});

        // Abort during TXRAMP at 1/1: ramp-down starts from 1/1.
        cfg_pdrv = 2'd3; cfg_ndrv = 2'd3; en_req = 1'b1;
        wait_hi("start2", 0, 6);
        cyc(16);
        check_drv("abort_at", 2'd1, 2'd1);
        en_req = 1'b0;
        cyc(1);
        check("abort_busy", {7'h0, busy}, 8'h01);
        check_drv("abort_hold0", 2'd1, 2'd1);
        cyc(3); check_drv("abort_hold3", 2'd1, 2'd1);
        cyc(1); check_drv("abort_dec",   2'd0, 2'd0);
        cyc(4);
        check("abort_idle_busy", {7'h0, busy},  8'h00);
        check("abort_idle_txen", {7'h0, itxen}, 8'h00);

        // Power-good loss in ACTIVE, then automatic re-sequencing.
        cfg_pdrv = 2'd1; cfg_ndrv = 2'd0; en_req = 1'b1;
        wait_hi("start3", 0, 6);
        cyc(20);
        check("por_pre_ack", {7'h0, en_ack}, 8'h01);
        check_drv("por_pre_drv", 2'd1, 2'd0);
        por_aib_vcchssi = 1'b1;
        cyc(1);
        por_aib_vcchssi = 1'b0;
        check("por_p1_ack", {7'h0, en_ack}, 8'h01);
        cyc(1);
        check("por_p2_ack", {7'h0, en_ack}, 8'h01);
        cyc(1);
        check("por_ack",   {7'h0, en_ack},   8'h00);
        check("por_busy",  {7'h0, busy},     8'h00);
        check("por_txen",  {7'h0, itxen},    8'h00);
        check("por_rxen",  {5'h0, irxen},    8'h00);
        check("por_prst",  {7'h0, ipadrstb}, 8'h00);
        check_drv("por_drv", 2'd0, 2'd0);
        check("por_wpd",   {7'h0, test_weakpd}, {7'h0, WP});
        cyc(1);
        check("reseq_busy", {7'h0, busy},     8'h01);
        check("reseq_prst", {7'h0, ipadrstb}, 8'h00);
        wait_hi("reseq_ack", 1, 25);
        check_drv("reseq_drv", 2'd1, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aibcr3_bufseq_ctl.md
AIBCR3_BUFSEQ_CTL -- requirements
Module: aibcr3_bufseq_ctl

Interface
REQ-001 SHALL have parameter PADRST_CYC, default 8, meaning cycles ipadrstb is held low before RX enable (min 1).
REQ-002 SHALL have parameter SETTLE_CYC, default 4, meaning dwell cycles per sequencing step (min 1).
REQ-003 SHALL have parameter RXEN_ON, default 3'b001, meaning irxen code when receiver enabled.
REQ-004 SHALL have parameter RXEN_OFF, default 3'b000, meaning irxen code when receiver disabled.
REQ-005 SHALL have one clock and an asynchronous active-low reset, exactly as listed in REQ-006 and REQ-007.
REQ-006 SHALL have port iclk, input, 1, meaning sequencer clock; all logic is on its rising edge.
REQ-007 SHALL have port irstb, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have port por_aib_vcc1, input, 1, meaning high = vcc1 domain not power-good.
REQ-009 SHALL have port por_aib_vcchssi, input, 1, meaning high = vcchssi domain not power-good.
REQ-010 SHALL have port en_req, input, 1, meaning level request to bring the buffer up (1) or down (0).
REQ-011 SHALL have port cfg_pdrv, input, 2, meaning target pull-up drive code.
REQ-012 SHALL have port cfg_ndrv, input, 2, meaning target pull-down drive code.
REQ-013 SHALL have port en_ack, output, 1, meaning buffer fully up (ACTIVE).
REQ-014 SHALL have port busy, output, 1, meaning the sequencer is in a transition state.
REQ-015 SHALL have port ipadrstb, output, 1, meaning pad reset to the buffer.
REQ-016 SHALL have port irxen, output, 3, meaning receiver enable code.
REQ-017 SHALL have port itxen, output, 1, meaning transmitter enable.
REQ-018 SHALL have port ipdrv, output, 2, meaning applied pull-up drive code.
REQ-019 SHALL have port indrv, output, 2, meaning applied pull-down drive code.
REQ-020 SHALL have port test_weakpu, output, 1, meaning weak pull-up enable.
REQ-021 SHALL have port test_weakpd, output, 1, meaning weak pull-down enable.
REQ-022 SHALL register all outputs; no combinational input-to-output path.

Function
REQ-023 SHALL define por_ok = !(por_aib_vcc1 | por_aib_vcchssi), sampled through a 2-flop synchronizer.
REQ-024 SHALL implement states IDLE, PADRST, RXON, TXRAMP, ACTIVE, RAMPDN.
REQ-025 SHALL transition IDLE->PADRST when en_req=1 and por_ok=1, capturing cfg_pdrv/cfg_ndrv into target registers.
REQ-026 SHALL hold ipadrstb=0 for PADRST_CYC cycles in PADRST, then set ipadrstb=1, irxen=RXEN_ON, and enter RXON.
REQ-027 SHALL dwell SETTLE_CYC cycles in RXON, then set itxen=1 and enter TXRAMP with drive codes 0.
REQ-028 SHALL, in TXRAMP, increment each of ipdrv/indrv by 1, saturating at its target, every SETTLE_CYC cycles; when both equal their targets it SHALL enter ACTIVE.
REQ-029 SHALL, with target 0/0, pass through TXRAMP in SETTLE_CYC cycles.
REQ-030 SHALL assert en_ack only in ACTIVE, and busy only in PADRST, RXON, TXRAMP, and RAMPDN.
REQ-031 SHALL ignore cfg_* changes outside the IDLE->PADRST capture.
REQ-032 SHALL enter RAMPDN on en_req=0 in PADRST, RXON, TXRAMP, or ACTIVE, starting from the current drive codes.
REQ-033 SHALL, in RAMPDN, decrement each nonzero drive code by 1 every SETTLE_CYC cycles; at 0/0 it SHALL deassert itxen, set irxen=RXEN_OFF and ipadrstb=0, and enter IDLE, all on one edge.
REQ-034 SHALL, in RAMPDN, ignore en_req=1 until IDLE is reached.
REQ-035 SHALL, on por_ok=0 in any state, force the reset values of REQ-036 on the next edge and enter IDLE.

Reset
REQ-036 SHALL, on irstb=0, asynchronously force state=IDLE, ipadrstb=0, irxen=RXEN_OFF, itxen=0, ipdrv=0, indrv=0, en_ack=0, busy=0, timer=0, synchronizer=0 (por_ok=0), and weak pulls per REQ-038/REQ-039.

Configuration
REQ-037 SHALL compile the weak-pull feature with macro AIBCR3_BUFSEQ_WEAKPULL_EN.
REQ-038 SHALL, with AIBCR3_BUFSEQ_WEAKPULL_EN defined, drive test_weakpd=1 in IDLE and PADRST and 0 elsewhere, and drive test_weakpu=0 always.
REQ-039 SHALL, without AIBCR3_BUFSEQ_WEAKPULL_EN, tie test_weakpu=0 and test_weakpd=0.

Structure
REQ-040 SHALL place the state enum and a 2-bit drive-code typedef in package aibcr3_bufseq_pkg.
REQ-041 SHALL implement the dwell counter as sub-module aibcr3_bufseq_tmr (load/count/done).

Verification
REQ-042 SHALL verify that, with defaults, por_ok, and en_req rising with cfg 2'b11/2'b10, ipadrstb stays low 8 cycles, irxen=3'b001 follows, itxen follows 4 cycles later, drive ramps 1/1->2/2->3/2, and en_ack=1 occurs after the last 4-cycle dwell.
REQ-043 SHALL verify that en_req=0 in ACTIVE at 3/2 steps drive to 2/1, then 1/0, then 0/0, then reaches IDLE with itxen=0 and en_ack=0.
REQ-044 SHALL verify that en_req dropping in TXRAMP at 1/1 causes RAMPDN from 1/1 with no further increment.
REQ-045 SHALL verify that por_aib_vcchssi pulsing high in ACTIVE forces all outputs to reset values within 3 cycles and en_req=1 is then re-sequenced after por_ok.
REQ-046 SHALL verify that with the macro on, test_weakpd=1 in IDLE and 0 in ACTIVE; with it off, both weak outputs are 0 throughout.
